// File: rtl/brush_engine_if.sv
// rtl/brush_engine_if.sv - framebuffer write port between the brush engine and the frame store
interface brush_engine_if #(
    parameter int HPOS_WIDTH  = 10,
    parameter int VPOS_WIDTH  = 10,
    parameter int COLOR_WIDTH = 3
);
    logic                   wr_req;
    logic [HPOS_WIDTH-1:0]  wr_x;
    logic [VPOS_WIDTH-1:0]  wr_y;
    logic [COLOR_WIDTH-1:0] wr_color;
    logic                   wr_ack;

    modport master (output wr_req, wr_x, wr_y, wr_color, input wr_ack);
    modport slave  (input wr_req, wr_x, wr_y, wr_color, output wr_ack);
endinterface

// File: rtl/brush_engine.sv
// rtl/brush_engine.sv - button-driven square brush with border overlay and framebuffer stamping
module brush_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int HPOS_WIDTH  = 10,
    parameter int VPOS_WIDTH  = 10,
    parameter int SLOWNESS    = 16,
    parameter int SIZE_BASE   = 10,
    parameter int SIZE_STEP   = 10,
    parameter int SIZE_COUNT  = 3,
    parameter int ACCEL_TICKS = 32,
    parameter int ACCEL_STEP  = 4,
    parameter int COLOR_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             i_btn,
    input  logic [3:0]             i_btn_rise,
    input  logic                   i_display_on,
    input  logic [HPOS_WIDTH-1:0]  i_hpos,
    input  logic [VPOS_WIDTH-1:0]  i_vpos,
    input  logic [COLOR_WIDTH-1:0] i_fb_rgb,
    output logic [COLOR_WIDTH-1:0] o_rgb,
    brush_engine_if.master         wr
);
    localparam int AW = (HPOS_WIDTH > VPOS_WIDTH ? HPOS_WIDTH : VPOS_WIDTH) + 2;
    localparam int IW = (SIZE_COUNT > 1) ? $clog2(SIZE_COUNT) : 1;
    localparam int HW = $clog2(ACCEL_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_STAMP, S_DONE} state_t;
    typedef logic signed [AW-1:0] coord_t;

    state_t                 r_state;
    logic [HPOS_WIDTH-1:0]  r_x, r_x0, r_xe;
    logic [VPOS_WIDTH-1:0]  r_y, r_ye;
    logic [IW-1:0]          r_idx;
    logic [COLOR_WIDTH-1:0] r_color;
    logic                   r_paint_en;
    logic                   r_kick;
    logic [SLOWNESS-1:0]    r_tick;
    logic [HW-1:0]          r_hold;

    coord_t w_size, w_step, w_x, w_y, w_nx, w_ny;
    coord_t w_hpos, w_vpos, w_left, w_right, w_top, w_bottom;
    logic   w_tick, w_start, w_can, w_toggle, w_in_h, w_in_v, w_border, w_pos_change;
    logic   w_unused;

    assign w_size   = coord_t'(SIZE_BASE) + coord_t'(r_idx) * coord_t'(SIZE_STEP);
    assign w_step   = (r_hold >= HW'(ACCEL_TICKS)) ? coord_t'(ACCEL_STEP) : coord_t'(1);
    assign w_x      = coord_t'(r_x);
    assign w_y      = coord_t'(r_y);
    assign w_tick   = i_display_on && (&r_tick);
    assign w_toggle = i_btn_rise[3] && (i_btn[1:0] == 2'b11);
    // A pending stamp wins over any move/size/colour change arriving on the same cycle
    assign w_start  = (r_state == S_IDLE) && r_kick && r_paint_en;
    assign w_can    = (r_state == S_IDLE) && !w_start;

    always_comb begin
        w_nx = w_x;
        w_ny = w_y;
        if (w_can && w_tick && i_btn[0])
            w_nx = i_btn[2] ? w_x + w_step : w_x - w_step;
        if (w_can && w_tick && i_btn[1])
            w_ny = i_btn[2] ? w_y + w_step : w_y - w_step;
        // Clamping every cycle also pulls the brush back in after a size increase
        if (w_nx < w_size)
            w_nx = w_size;
        else if (w_nx > coord_t'(H_RES) - w_size)
            w_nx = coord_t'(H_RES) - w_size;
        if (w_ny < w_size)
            w_ny = w_size;
        else if (w_ny > coord_t'(V_RES) - w_size)
            w_ny = coord_t'(V_RES) - w_size;
    end

    assign w_pos_change = (w_nx != w_x) || (w_ny != w_y);

    assign w_hpos   = coord_t'(i_hpos);
    assign w_vpos   = coord_t'(i_vpos);
    assign w_left   = w_x - w_size;
    assign w_right  = w_x + w_size - coord_t'(1);
    assign w_top    = w_y - w_size;
    assign w_bottom = w_y + w_size - coord_t'(1);
    assign w_in_h   = (w_hpos >= w_left) && (w_hpos <= w_right);
    assign w_in_v   = (w_vpos >= w_top) && (w_vpos <= w_bottom);
    assign w_border = (w_in_v && ((w_hpos == w_left) || (w_hpos == w_right))) ||
                      (w_in_h && ((w_vpos == w_top) || (w_vpos == w_bottom)));

    assign w_unused = ^{i_btn[3], i_btn_rise[2:0], w_nx[AW-1:HPOS_WIDTH], w_ny[AW-1:VPOS_WIDTH]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_x         <= HPOS_WIDTH'(H_RES / 2);
            r_y         <= VPOS_WIDTH'(V_RES / 2);
            r_x0        <= '0;
            r_xe        <= '0;
            r_ye        <= '0;
            r_idx       <= '0;
            r_color     <= '1;
            r_paint_en  <= 1'b0;
            r_kick      <= 1'b0;
            r_tick      <= '0;
            r_hold      <= '0;
            o_rgb       <= '0;
            wr.wr_req   <= 1'b0;
            wr.wr_x     <= '0;
            wr.wr_y     <= '0;
            wr.wr_color <= '0;
        end else begin
            r_x    <= w_nx[HPOS_WIDTH-1:0];
            r_y    <= w_ny[VPOS_WIDTH-1:0];
            r_kick <= w_pos_change || (w_toggle && !r_paint_en);
            if (i_display_on)
                r_tick <= r_tick + 1'b1;
            if (i_btn[1:0] == 2'b00)
                r_hold <= '0;
            else if (w_can && w_tick && (r_hold != HW'(ACCEL_TICKS)))
                r_hold <= r_hold + 1'b1;
            if (w_toggle)
                r_paint_en <= !r_paint_en;
            if (w_can && i_btn_rise[3] && (i_btn[2:0] == 3'b100))
                r_idx <= (r_idx == IW'(SIZE_COUNT - 1)) ? '0 : r_idx + 1'b1;
            if (w_can && i_btn_rise[3] && (i_btn[2:0] == 3'b000))
                r_color <= r_color + 1'b1;
            o_rgb <= !i_display_on ? '0 : (w_border ? r_color : i_fb_rgb);

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_STAMP;
                        r_x0        <= w_left[HPOS_WIDTH-1:0];
                        r_xe        <= w_right[HPOS_WIDTH-1:0];
                        r_ye        <= w_bottom[VPOS_WIDTH-1:0];
                        wr.wr_req   <= 1'b1;
                        wr.wr_x     <= w_left[HPOS_WIDTH-1:0];
                        wr.wr_y     <= w_top[VPOS_WIDTH-1:0];
                        wr.wr_color <= r_color;
                    end
                end
                S_STAMP: begin
                    if (wr.wr_ack) begin
                        if (wr.wr_x != r_xe) begin
                            wr.wr_x <= wr.wr_x + 1'b1;
                        end else begin
                            wr.wr_x <= r_x0;
                            if (wr.wr_y != r_ye) begin
                                wr.wr_y <= wr.wr_y + 1'b1;
                            end else begin
                                wr.wr_req <= 1'b0;
                                r_state   <= S_DONE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brush_engine.sv
// tb/tb_brush_engine.sv - randomized self-checking bench for brush_engine against a behavioural model
module tb_brush_engine;
    localparam int H = 640, V = 480, SB = 10, SS = 10, SC = 3, AT = 32, AS = 4, SL = 2;
    localparam int TICKMAX = (1 << SL) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn, rise;
    logic       disp, ack;
    logic [9:0] hpos, vpos;
    logic [2:0] fb, rgb;

    int n_assert = 0;
    int n_fail   = 0;

    int mx = 320, my = 240, midx = 0, mcol = 7, mpaint = 0, mtick = 0, mhold = 0;
    int mkick = 0, mdone = 0, mrgb = 0;
    int qx[$], qy[$], qc[$];

    always #5 clk = ~clk;

    brush_engine_if #(.HPOS_WIDTH(10), .VPOS_WIDTH(10), .COLOR_WIDTH(3)) wr ();
    assign wr.wr_ack = ack;

    brush_engine #(.SLOWNESS(SL)) dut (
        .clk(clk), .reset(rst), .i_btn(btn), .i_btn_rise(rise), .i_display_on(disp),
        .i_hpos(hpos), .i_vpos(vpos), .i_fb_rgb(fb), .o_rgb(rgb), .wr(wr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit on_border(input int h, input int v, input int x, input int y, input int s);
        bit in_sq;
        in_sq = (h >= x - s) && (h < x + s) && (v >= y - s) && (v < y + s);
        return in_sq && (h == x - s || h == x + s - 1 || v == y - s || v == y + s - 1);
    endfunction

    task automatic model_reset();
        mx = H / 2; my = V / 2; midx = 0; mcol = 7; mpaint = 0; mtick = 0; mhold = 0;
        mkick = 0; mdone = 0; mrgb = 0;
        qx.delete(); qy.delete(); qc.delete();
    endtask

    task automatic model_step();
        int  s, step, nx, ny;
        bit  idle, start, can, tick, tog;
        s     = SB + midx * SS;
        idle  = (qx.size() == 0) && (mdone == 0);
        start = idle && (mkick != 0) && (mpaint != 0);
        can   = idle && !start;
        tick  = disp && (mtick == TICKMAX);
        tog   = rise[3] && (btn[1:0] == 2'b11);
        mrgb  = !disp ? 0 : (on_border(int'(hpos), int'(vpos), mx, my, s) ? mcol : int'(fb));
        step  = (mhold >= AT) ? AS : 1;
        nx = mx;
        ny = my;
        if (can && tick && btn[0]) nx = btn[2] ? nx + step : nx - step;
        if (can && tick && btn[1]) ny = btn[2] ? ny + step : ny - step;
        nx = clampi(nx, s, H - s);
        ny = clampi(ny, s, V - s);
        if (mdone != 0) begin
            mdone = 0;
        end else if (qx.size() > 0) begin
            if (ack) begin
                void'(qx.pop_front()); void'(qy.pop_front()); void'(qc.pop_front());
                if (qx.size() == 0) mdone = 1;
            end
        end else if (start) begin
            for (int yy = my - s; yy < my + s; yy++)
                for (int xx = mx - s; xx < mx + s; xx++) begin
                    qx.push_back(xx); qy.push_back(yy); qc.push_back(mcol);
                end
        end
        mkick = ((nx != mx) || (ny != my) || (tog && mpaint == 0)) ? 1 : 0;
        mx = nx;
        my = ny;
        if (btn[1:0] == 2'b00) mhold = 0;
        else if (can && tick && mhold < AT) mhold++;
        if (can && rise[3] && btn[2:0] == 3'b100) midx = (midx + 1) % SC;
        if (can && rise[3] && btn[2:0] == 3'b000) mcol = (mcol + 1) % 8;
        if (tog) mpaint = 1 - mpaint;
        if (disp) mtick = (mtick + 1) % (TICKMAX + 1);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        chk("wr_req", int'(wr.wr_req), (qx.size() > 0) ? 1 : 0);
        if (qx.size() > 0) begin
            chk("wr_x", int'(wr.wr_x), qx[0]);
            chk("wr_y", int'(wr.wr_y), qy[0]);
            chk("wr_color", int'(wr.wr_color), qc[0]);
        end
        chk("rgb", int'(rgb), mrgb);
        chk("pos_x", int'(dut.r_x), mx);
        chk("pos_y", int'(dut.r_y), my);
    end

    task automatic cyc();
        int s;
        @(posedge clk);
        #1;
        s    = SB + midx * SS;
        hpos = 10'(mx - s - 1 + int'($urandom_range(2 * s + 1)));
        vpos = 10'(my - s - 1 + int'($urandom_range(2 * s + 1)));
        fb   = 3'($urandom);
    endtask

    task automatic press(input logic [3:0] b);
        btn  = b;
        rise = 4'b1000;
        cyc();
        rise = 4'b0000;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wr_req"}, int'(wr.wr_req), 0);
        chk({tag, "_wr_x"}, int'(wr.wr_x), 0);
        chk({tag, "_wr_y"}, int'(wr.wr_y), 0);
        chk({tag, "_wr_color"}, int'(wr.wr_color), 0);
        chk({tag, "_rgb"}, int'(rgb), 0);
        chk({tag, "_x"}, int'(dut.r_x), 320);
        chk({tag, "_y"}, int'(dut.r_y), 240);
        chk({tag, "_idx"}, int'(dut.r_idx), 0);
        chk({tag, "_color"}, int'(dut.r_color), 7);
        chk({tag, "_paint"}, int'(dut.r_paint_en), 0);
    endtask

    // Runs up to 'limit' cycles with random acks, checking that a stalled write holds still.
    task automatic stamp_cycles(input int limit, input bit until_idle, output bit ended);
        int  sx, sy, sc;
        bit  stall;
        ended = 0;
        for (int i = 0; i < limit; i++) begin
            ack   = ($urandom_range(2) != 0);
            stall = wr.wr_req && !ack;
            sx = int'(wr.wr_x); sy = int'(wr.wr_y); sc = int'(wr.wr_color);
            cyc();
            if (stall) begin
                chk("stall_x", int'(wr.wr_x), sx);
                chk("stall_y", int'(wr.wr_y), sy);
                chk("stall_color", int'(wr.wr_color), sc);
            end
            if (until_idle && !wr.wr_req) begin
                ended = 1;
                break;
            end
        end
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = wr.wr_req;
        end
        chk(name, int'(seen), 1);
    endtask

    initial begin
        int  n, fx, fy, lx, ly;
        bit  ended;
        btn = 0; rise = 0; disp = 0; hpos = 0; vpos = 0; fb = 0; ack = 0; rst = 1;
        repeat (3) cyc();
        reset_checks("reset");
        rst = 0;

        // Acceleration: 32 ticks at step 1 then step 4
        disp = 1;
        btn  = 4'b0101;
        repeat (160) cyc();
        chk("model_accel_x", mx, 384);
        chk("accel_x", int'(dut.r_x), 384);

        // Left move at step 4 lands on the lower bound and stays there
        btn = 4'b0001;
        repeat (372) cyc();
        chk("left_x12", int'(dut.r_x), 12);
        repeat (28) cyc();
        chk("model_left_clamp", mx, 10);
        chk("left_clamp", int'(dut.r_x), 10);

        // Size cycling and clamp after growth
        press(4'b0100);
        chk("size20", SB + int'(dut.r_idx) * SS, 20);
        cyc();
        chk("grow_clamp_low", int'(dut.r_x), 20);
        btn = 4'b0101;
        repeat (800) cyc();
        chk("right_x620", int'(dut.r_x), 620);
        press(4'b0100);
        chk("size30", SB + int'(dut.r_idx) * SS, 30);
        chk("x_before_clamp", int'(dut.r_x), 620);
        cyc();
        chk("grow_clamp_610", int'(dut.r_x), 610);
        press(4'b0100);
        chk("size10", SB + int'(dut.r_idx) * SS, 10);

        // Full stamp with acknowledge tied high
        rst = 1;
        cyc(); cyc();
        rst  = 0;
        disp = 0;
        press(4'b0011);
        btn  = 4'b0000;
        disp = 1;
        ack  = 1;
        n = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (wr.wr_req) begin
                if (n == 0) begin fx = int'(wr.wr_x); fy = int'(wr.wr_y); end
                lx = int'(wr.wr_x); ly = int'(wr.wr_y);
                n++;
            end else if (n > 0) begin
                break;
            end
        end
        chk("stamp_count", n, 400);
        chk("stamp_first_x", fx, 310);
        chk("stamp_first_y", fy, 230);
        chk("stamp_last_x", lx, 329);
        chk("stamp_last_y", ly, 249);
        cyc();
        chk("idle_after_done", int'(wr.wr_req), 0);

        // Stalled stamp with a move request that must be ignored
        btn = 4'b0101;
        wait_req("stamp2_start");
        stamp_cycles(100, 0, ended);
        btn = 4'b0000;
        stamp_cycles(3000, 1, ended);
        chk("stamp2_end", int'(ended), 1);
        chk("model_move_ignored", mx, 321);
        chk("move_ignored_x", int'(dut.r_x), 321);

        // Reset in the middle of a stamp
        btn = 4'b0101;
        wait_req("stamp3_start");
        btn = 4'b0000;
        stamp_cycles(10, 0, ended);
        #2;
        rst = 1;
        #1;
        reset_checks("midreset");
        cyc();
        rst = 0;

        // Randomized operation
        for (int i = 0; i < 8000; i++) begin
            if (i % 32 == 0) btn = 4'($urandom);
            rise = ($urandom_range(47) == 0) ? 4'b1000 : 4'b0000;
            disp = ($urandom_range(4) != 0);
            ack  = ($urandom_range(2) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
